// File: rtl/musi_bus_master.sv
// USI bus master: queues CSR manual commands in a small FIFO
// and runs each one as a single write or read on a one-hot slave bus.
module musi_bus_master #(
  parameter int pBusWidth  = 8,
  parameter int pSelLsb    = 24,
  parameter int pFifoDepth = 4,
  parameter int pTimeout   = 255
) (
  input  logic                       iSysClk,
  input  logic                       iSysRst,
  input  logic [31:0]                iMUsiWd,
  input  logic [31:0]                iMUsiAdrs,
  input  logic                       iMUsiWCke,
  input  logic                       iErrClr,
  output logic [31:0]                oMUsiRd,
  output logic [pBusWidth:0]         oMUsiVd,
  output logic                       oMUsiRdDone,
  output logic [2:0]                 oMUsiErr,
  output logic                       oMUsiBusy,
  output logic [31:0]                oSUsiWd,
  output logic [29:0]                oSUsiAdrs,
  output logic                       oSUsiWEd,
  output logic                       oSUsiREd,
  output logic [pBusWidth:0]         oSUsiCs,
  input  logic [pBusWidth:0]         iSUsiRdy,
  input  logic [32*(pBusWidth+1)-1:0] iSUsiRd,
  input  logic [pBusWidth:0]         iSUsiRdVd
);

  localparam int N  = pBusWidth + 1;
  localparam int AW = $clog2(pFifoDepth);
  localparam logic [7:0] TMO_LAST = 8'(pTimeout - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        wcke_q;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [63:0] mem_q [pFifoDepth];
  logic [7:0]  tmo_q, tmo_d;
  logic [N-1:0] selh_q, selh_d;
  logic [N-1:0] cs_q, cs_d;
  logic [N-1:0] vd_q, vd_d;
  logic [31:0] wd_q, wd_d;
  logic [29:0] adrs_q, adrs_d;
  logic        wed_q, wed_d;
  logic        red_q, red_d;
  logic [31:0] rd_q, rd_d;
  logic        done_q, done_d;
  logic [2:0]  err_q, err_d;

  logic [1:0]  cmd_w;
  logic [5:0]  sel_w;
  logic        rise_w;
  logic        cmd_ok_w;
  logic        bad_w;
  logic        full_w;
  logic        empty_w;
  logic        push_w;
  logic        pop_w;
  logic        ovf_w;
  logic [63:0] head_w;
  logic [5:0]  hsel_w;
  logic        rdy_hit_w;
  logic        vd_hit_w;
  logic        tmo_end_w;
  logic        tmo_err_w;
  logic [31:0] rsel_w;
  logic [N-1:0] one_w;

  assign one_w  = {{(N-1){1'b0}}, 1'b1};
  assign cmd_w  = iMUsiAdrs[31:30];
  assign sel_w  = iMUsiAdrs[pSelLsb+5:pSelLsb];
  assign rise_w = iMUsiWCke & ~wcke_q;

  // cmd 0 is a silent no-op; cmd 3 or an out-of-range slave is an error
  assign cmd_ok_w = (cmd_w == 2'd1 || cmd_w == 2'd2) &&
                    (sel_w <= 6'(pBusWidth));
  assign bad_w = rise_w && cmd_w != 2'd0 && !cmd_ok_w;

  assign empty_w = (wptr_q == rptr_q);
  assign full_w  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign pop_w  = (state_q == S_IDLE) && !empty_w;
  assign push_w = rise_w && cmd_ok_w && (!full_w || pop_w);
  assign ovf_w  = rise_w && cmd_ok_w && full_w && !pop_w;

  assign head_w = mem_q[rptr_q[AW-1:0]];
  assign hsel_w = head_w[pSelLsb+5+32:pSelLsb+32];

  assign rdy_hit_w = |(iSUsiRdy & selh_q);
  assign vd_hit_w  = |(iSUsiRdVd & selh_q);
  assign tmo_end_w = (tmo_q == TMO_LAST);
  assign tmo_err_w = tmo_end_w &&
    ((state_q == S_REQ && !rdy_hit_w) ||
     (state_q == S_WAIT && !vd_hit_w));

  always_comb begin
    rsel_w = '0;
    for (int i = 0; i < N; i++) begin
      rsel_w = rsel_w | (iSUsiRd[32*i +: 32] & {32{selh_q[i]}});
    end
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!empty_w) state_d = S_REQ;
      S_REQ: begin
        if (rdy_hit_w)      state_d = red_q ? S_WAIT : S_IDLE;
        else if (tmo_end_w) state_d = S_IDLE;
      end
      S_WAIT: if (vd_hit_w || tmo_end_w) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wd_d   = wd_q;
    adrs_d = adrs_q;
    wed_d  = wed_q;
    red_d  = red_q;
    cs_d   = cs_q;
    selh_d = selh_q;
    tmo_d  = tmo_q;
    rd_d   = rd_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_w) begin
          wd_d   = head_w[31:0];
          adrs_d = head_w[61:32];
          wed_d  = (head_w[63:62] == 2'd1);
          red_d  = (head_w[63:62] == 2'd2);
          cs_d   = one_w << hsel_w;
          selh_d = one_w << hsel_w;
          tmo_d  = '0;
        end
      end
      S_REQ: begin
        tmo_d = tmo_q + 8'd1;
        if (rdy_hit_w || tmo_end_w) begin
          wd_d   = '0;
          adrs_d = '0;
          wed_d  = 1'b0;
          red_d  = 1'b0;
          cs_d   = '0;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        if (vd_hit_w) begin
          rd_d   = rsel_w;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push_w);
    rptr_d = rptr_q + (AW+1)'(pop_w);
    vd_d   = iSUsiRdy & {N{~full_w}};
    err_d  = iErrClr ? 3'b000 : err_q;
    err_d  = err_d | {tmo_err_w, bad_w, ovf_w};
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      wcke_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      tmo_q  <= '0;
      selh_q <= '0;
      cs_q   <= '0;
      vd_q   <= '0;
      wd_q   <= '0;
      adrs_q <= '0;
      wed_q  <= 1'b0;
      red_q  <= 1'b0;
      rd_q   <= '0;
      done_q <= 1'b0;
      err_q  <= '0;
    end else begin
      wcke_q <= iMUsiWCke;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      tmo_q  <= tmo_d;
      selh_q <= selh_d;
      cs_q   <= cs_d;
      vd_q   <= vd_d;
      wd_q   <= wd_d;
      adrs_q <= adrs_d;
      wed_q  <= wed_d;
      red_q  <= red_d;
      rd_q   <= rd_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // storage needs no reset; pointers define what is valid
  always_ff @(posedge iSysClk) begin
    if (push_w) begin
      mem_q[wptr_q[AW-1:0]] <= {cmd_w, iMUsiAdrs[29:0], iMUsiWd};
    end
  end

  assign oMUsiRd     = rd_q;
  assign oMUsiVd     = vd_q;
  assign oMUsiRdDone = done_q;
  assign oMUsiErr    = err_q;
  assign oMUsiBusy   = (state_q != S_IDLE) || !empty_w;
  assign oSUsiWd     = wd_q;
  assign oSUsiAdrs   = adrs_q;
  assign oSUsiWEd    = wed_q;
  assign oSUsiREd    = red_q;
  assign oSUsiCs     = cs_q;

endmodule
